mc_ctrl: RTL
============

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low (0 = reset).
REQ-003 SHALL have port: instr_code  input  6  opcode field of instruction register.
REQ-004 SHALL have port: funct  input  6  funct field of instruction register.
REQ-005 SHALL have port: mem_ready  input  1  memory completes the access this cycle.
REQ-006 SHALL have port: alu_zero  input  1  ALU result equals zero.
REQ-007 SHALL have outputs (all 1 bit): pc_we, ir_we, reg_we, mem_re, mem_we, ext_op (1 = sign, 0 = zero), retire, illegal.
REQ-008 SHALL have outputs: alu_src_b 2 (0 = rt, 1 = const 4, 2 = ext imm); alu_op 2 (0 ADD, 1 SUB, 2 OR, 3 LUI); reg_dst 2 (0 rt, 1 rd, 2 r31); mem_to_reg 2 (0 ALU, 1 mem, 2 PC); pc_src 2 (0 PC+4, 1 branch target, 2 jump target, 3 rs).
REQ-009 SHALL have outputs: state 4 (current FSM state); instr_count 32 (retired instruction count).

Function
REQ-010 SHALL be a Moore FSM sequencing the multi-cycle datapath: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, JUMP=11.
REQ-011 SHALL decode: opcode 0x00 with funct 0x21 addu / 0x23 subu / 0x08 jr; 0x0d ori; 0x0f lui; 0x23 lw; 0x2b sw; 0x04 beq; 0x02 j; 0x03 jal.
REQ-012 SHALL transition IDLE -> FETCH unconditionally on the first edge after reset release.
REQ-013 In FETCH SHALL assert mem_re; stay in FETCH while mem_ready = 0; when mem_ready = 1, assert ir_we and pc_we (pc_src 0) in that cycle and go to DECODE.
REQ-014 DECODE SHALL last one cycle, going to EXEC_R (addu/subu), JUMP (jr/j/jal), EXEC_I (ori/lui), MEM_ADDR (lw/sw), BRANCH (beq).
REQ-015 Illegal opcode/funct in DECODE SHALL pulse illegal for that cycle, return to FETCH, write nothing, and not count as retired.
REQ-016 EXEC_R SHALL drive alu_src_b 0, alu_op ADD (addu) or SUB (subu), then go to WB_ALU; WB_ALU SHALL assert reg_we with reg_dst 1 for R-type, 0 for I-type, mem_to_reg 0.
REQ-017 EXEC_I SHALL drive alu_src_b 2, ext_op 0, alu_op OR (ori) or LUI (lui), then go to WB_ALU.
REQ-018 MEM_ADDR SHALL drive alu_src_b 2, ext_op 1, alu_op ADD, then go to MEM_RD (lw) or MEM_WR (sw).
REQ-019 MEM_RD/MEM_WR SHALL hold mem_re/mem_we until mem_ready = 1; MEM_RD then goes to WB_MEM (reg_we, reg_dst 0, mem_to_reg 1); MEM_WR then goes to FETCH.
REQ-020 BRANCH SHALL drive alu_src_b 0, alu_op SUB, pc_src 1, pc_we = alu_zero (same cycle), then go to FETCH.
REQ-021 JUMP SHALL assert pc_we with pc_src 3 (jr) or 2 (j/jal); for jal SHALL also assert reg_we, reg_dst 2, mem_to_reg 2; then go to FETCH.
REQ-022 Every transition into FETCH from WB_ALU, WB_MEM, MEM_WR, BRANCH, JUMP SHALL pulse retire for that cycle and increment instr_count by 1, wrapping 0xFFFFFFFF -> 0.
REQ-023 Minimum latency with mem_ready always 1 (FETCH included): beq/j/jal/jr 3 cycles, R-type/I-type/sw 4, lw 5.
REQ-024 Outputs not listed for a state SHALL be 0; pc_we/ir_we SHALL depend combinationally only on state, mem_ready and alu_zero.

Reset
REQ-025 reset = 0 SHALL force state IDLE and instr_count 0 immediately, independent of clk.
REQ-026 In IDLE every output SHALL be 0; reset asserted mid-instruction (including a MEM_WR wait) SHALL abandon it with no further strobes.

Structure
REQ-027 State encodings, opcode/funct constants and alu_op/pc_src/reg_dst/mem_to_reg codes SHALL live in shared package mc_ctrl_pkg.
REQ-028 Opcode/funct classification SHALL be one combinational sub-module mc_decode; FSM, counter and output decode stay in mc_ctrl.

Verification
REQ-029 Reset, release, mem_ready = 1, addu (op 0x00, funct 0x21) -> states 0,1,2,3,8,1; reg_we = 1 only in WB_ALU with reg_dst 1; retire once; instr_count = 1.
REQ-030 lw (0x23), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_re = 1, then WB_MEM reg_we = 1, mem_to_reg 1.
REQ-031 beq (0x04) with alu_zero = 0 then 1 -> pc_we = 0 then 1 in BRANCH, pc_src 1; each 3 cycles.
REQ-032 jal (0x03) -> JUMP asserts pc_we, pc_src 2, reg_we, reg_dst 2, mem_to_reg 2; jr (funct 0x08) -> pc_src 3, reg_we 0.
REQ-033 opcode 0x3f -> illegal pulse in DECODE, next state FETCH, instr_count unchanged.
REQ-034 reset = 0 asserted mid-cycle in MEM_WR -> state 0 and all outputs 0 before next clk edge; instr_count 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle datapath controller.
package mc_ctrl_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned CNT_W   = 32;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_MEM_ADDR = 4'd5,
      S_MEM_RD   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_WB_ALU   = 4'd8,
      S_WB_MEM   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   // Instruction classes produced by the decoder
   typedef enum logic [3:0] {
      I_ILL, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI,
      I_LW, I_SW, I_BEQ, I_J, I_JAL
   } iclass_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

   localparam logic [OP_W-1:0] FN_JR    = 6'h08;
   localparam logic [OP_W-1:0] FN_ADDU  = 6'h21;
   localparam logic [OP_W-1:0] FN_SUBU  = 6'h23;

   localparam logic [1:0] SRC_RT  = 2'd0;
   localparam logic [1:0] SRC_IMM = 2'd2;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_OR  = 2'd2;
   localparam logic [1:0] ALU_LUI = 2'd3;

   localparam logic [1:0] RD_RT  = 2'd0;
   localparam logic [1:0] RD_RD  = 2'd1;
   localparam logic [1:0] RD_R31 = 2'd2;

   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_MEM = 2'd1;
   localparam logic [1:0] M2R_PC  = 2'd2;

   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;
   localparam logic [1:0] PC_RS  = 2'd3;

endpackage

// File: rtl/mc_decode.sv
// Opcode/funct classification into instruction classes.
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [OP_W-1:0] instr_code,
   input  logic [OP_W-1:0] funct,
   output iclass_t         iclass
);

   // Map opcode (and funct for R-type) to a class; anything else is illegal
   always_comb begin
      iclass = I_ILL;
      case (instr_code)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: iclass = I_ADDU;
               FN_SUBU: iclass = I_SUBU;
               FN_JR:   iclass = I_JR;
               default: iclass = I_ILL;
            endcase
         end
         OP_ORI:  iclass = I_ORI;
         OP_LUI:  iclass = I_LUI;
         OP_LW:   iclass = I_LW;
         OP_SW:   iclass = I_SW;
         OP_BEQ:  iclass = I_BEQ;
         OP_J:    iclass = I_J;
         OP_JAL:  iclass = I_JAL;
         default: iclass = I_ILL;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Moore FSM sequencing the multi-cycle datapath, plus retired-instruction counter.
module mc_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    instr_code,
   input  logic [OP_W-1:0]    funct,
   input  logic               mem_ready,
   input  logic               alu_zero,
   output logic               pc_we,
   output logic               ir_we,
   output logic               reg_we,
   output logic               mem_re,
   output logic               mem_we,
   output logic               ext_op,
   output logic               retire,
   output logic               illegal,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic [1:0]         pc_src,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   instr_count
);

   state_t  cur, nxt;
   iclass_t iclass;

   mc_decode u_decode (
      .instr_code (instr_code),
      .funct      (funct),
      .iclass     (iclass)
   );

   assign state = STATE_W'(cur);

   // State register; reset drops straight to IDLE, abandoning any access
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cur <= S_IDLE;
      else        cur <= nxt;
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      instr_count <= '0;
      else if (retire) instr_count <= instr_count + CNT_W'(1);
   end

   // Next state and per-state datapath controls
   always_comb begin
      nxt        = cur;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      ext_op     = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;
      alu_src_b  = SRC_RT;
      alu_op     = ALU_ADD;
      reg_dst    = RD_RT;
      mem_to_reg = M2R_ALU;
      pc_src     = PC_SEQ;
      case (cur)
         S_IDLE: nxt = S_FETCH;
         S_FETCH: begin
            mem_re = 1'b1;
            if (mem_ready) begin
               ir_we = 1'b1;
               pc_we = 1'b1;
               nxt   = S_DECODE;
            end
         end
         S_DECODE: begin
            case (iclass)
               I_ADDU, I_SUBU:    nxt = S_EXEC_R;
               I_JR, I_J, I_JAL:  nxt = S_JUMP;
               I_ORI, I_LUI:      nxt = S_EXEC_I;
               I_LW, I_SW:        nxt = S_MEM_ADDR;
               I_BEQ:             nxt = S_BRANCH;
               default: begin
                  illegal = 1'b1;
                  nxt     = S_FETCH;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_op = (iclass == I_SUBU) ? ALU_SUB : ALU_ADD;
            nxt    = S_WB_ALU;
         end
         S_EXEC_I: begin
            alu_src_b = SRC_IMM;
            alu_op    = (iclass == I_LUI) ? ALU_LUI : ALU_OR;
            nxt       = S_WB_ALU;
         end
         S_MEM_ADDR: begin
            alu_src_b = SRC_IMM;
            ext_op    = 1'b1;
            nxt       = (iclass == I_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_re = 1'b1;
            if (mem_ready) nxt = S_WB_MEM;
         end
         S_MEM_WR: begin
            mem_we = 1'b1;
            if (mem_ready) begin
               retire = 1'b1;
               nxt    = S_FETCH;
            end
         end
         S_WB_ALU: begin
            reg_we  = 1'b1;
            reg_dst = (iclass == I_ADDU || iclass == I_SUBU) ? RD_RD : RD_RT;
            retire  = 1'b1;
            nxt     = S_FETCH;
         end
         S_WB_MEM: begin
            reg_we     = 1'b1;
            mem_to_reg = M2R_MEM;
            retire     = 1'b1;
            nxt        = S_FETCH;
         end
         S_BRANCH: begin
            alu_op = ALU_SUB;
            pc_src = PC_BR;
            pc_we  = alu_zero;
            retire = 1'b1;
            nxt    = S_FETCH;
         end
         S_JUMP: begin
            pc_we  = 1'b1;
            pc_src = (iclass == I_JR) ? PC_RS : PC_JMP;
            if (iclass == I_JAL) begin
               reg_we     = 1'b1;
               reg_dst    = RD_R31;
               mem_to_reg = M2R_PC;
            end
            retire = 1'b1;
            nxt    = S_FETCH;
         end
         default: nxt = S_IDLE;
      endcase
   end

endmodule
